// File: rtl/mm2s_pkg.sv
// Shared types and constants for the MM2S descriptor-driven mover.
// FSM states, status bit indices and AXI burst/response encodings.
package mm2s_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ADDR,
        S_DATA,
        S_STAT
    } state_e;

    localparam int ST_SLVERR   = 0;
    localparam int ST_DECERR   = 1;
    localparam int ST_ZERO_LEN = 2;
    localparam int ST_MISALIGN = 3;

    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axis_mm2s_mover_if.sv
// AXI4 read channels (AR/R) plus the AXI4-Stream output of the mover.
// master = mover side, slave = memory/stream-sink side.
interface axis_mm2s_mover_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int UW = 65
);
    logic [AW-1:0]   m_axi_araddr;
    logic [7:0]      m_axi_arlen;
    logic [2:0]      m_axi_arsize;
    logic [1:0]      m_axi_arburst;
    logic            m_axi_arvalid;
    logic            m_axi_arready;
    logic [DW-1:0]   m_axi_rdata;
    logic [1:0]      m_axi_rresp;
    logic            m_axi_rlast;
    logic            m_axi_rvalid;
    logic            m_axi_rready;
    logic [DW-1:0]   m_axis_tdata;
    logic [DW/8-1:0] m_axis_tkeep;
    logic [UW-1:0]   m_axis_tuser;
    logic            m_axis_tlast;
    logic            m_axis_tvalid;
    logic            m_axis_tready;

    modport master (
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        output m_axi_arvalid, m_axi_rready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tuser,
        output m_axis_tlast, m_axis_tvalid,
        input  m_axi_arready, m_axi_rdata, m_axi_rresp,
        input  m_axi_rlast, m_axi_rvalid, m_axis_tready
    );

    modport slave (
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        input  m_axi_arvalid, m_axi_rready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tuser,
        input  m_axis_tlast, m_axis_tvalid,
        output m_axi_arready, m_axi_rdata, m_axi_rresp,
        output m_axi_rlast, m_axi_rvalid, m_axis_tready
    );

endinterface

// File: rtl/mm2s_burst_calc.sv
// Next AR burst length: min(beats_rem, MAX_BURST, beats left in the 4 KB page).
// page_off is addr[11:0]; the address is assumed beat-aligned.
module mm2s_burst_calc #(
    parameter int LW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 16
) (
    input  logic [11:0]   page_off,
    input  logic [LW-1:0] beats_rem,
    output logic [8:0]    burst
);
    localparam int LB = $clog2(DW / 8);

    logic [12:0] page_bytes;
    logic [12:0] page_beats;
    logic [8:0]  cap;

    always_comb begin
        page_bytes = 13'd4096 - {1'b0, page_off};
        page_beats = page_bytes >> LB;
        cap        = 9'(MAX_BURST);
        if (page_beats < 13'(MAX_BURST)) begin
            cap = page_beats[8:0];
        end
        burst = cap;
        if (beats_rem < LW'(cap)) begin
            burst = beats_rem[8:0];
        end
    end

endmodule

// File: rtl/axis_mm2s_mover.sv
// Descriptor-driven AXI4 read to AXI4-Stream mover with 4-bit status return.
// Optional perf counters enabled by defining MM2S_PERF_CNT_EN.
module axis_mm2s_mover
    import mm2s_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_LEN_WIDTH   = 32,
    parameter int AXIS_USER_WIDTH = 65,
    parameter int MAX_BURST       = 16
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic [AXI_LEN_WIDTH+AXI_ADDR_WIDTH-1:0] desc,
    input  logic [AXIS_USER_WIDTH-1:0]             desc_user,
    input  logic                                   desc_valid,
    output logic                                   desc_ready,
    output logic [3:0]                             status_error,
    output logic                                   status_valid,
`ifdef MM2S_PERF_CNT_EN
    output logic [31:0]                            perf_busy_cycles,
    output logic [31:0]                            perf_stall_cycles,
`endif
    axis_mm2s_mover_if.master                      bus
);
    localparam int AW = AXI_ADDR_WIDTH;
    localparam int LW = AXI_LEN_WIDTH;
    localparam int UW = AXIS_USER_WIDTH;
    localparam int B  = AXI_DATA_WIDTH / 8;
    localparam int LB = $clog2(B);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] len_q, len_d;
    logic [UW-1:0] user_q, user_d;
    logic [3:0]    err_q, err_d;
    logic [LW-1:0] beats_rem_q, beats_rem_d;
    logic [8:0]    burst_q, burst_d;
    logic [8:0]    beat_cnt_q, beat_cnt_d;

    logic [8:0]    burst_nxt;
    logic          beat;
    logic          last_beat;
    logic [B-1:0]  keep_last;
    logic [LB-1:0] rem;

    mm2s_burst_calc #(
        .LW        (LW),
        .DW        (AXI_DATA_WIDTH),
        .MAX_BURST (MAX_BURST)
    ) u_burst_calc (
        .page_off  (addr_q[11:0]),
        .beats_rem (beats_rem_q),
        .burst     (burst_nxt)
    );

    assign beat      = (state_q == S_DATA) && bus.m_axi_rvalid && bus.m_axis_tready;
    assign last_beat = (beats_rem_q == LW'(1));
    assign rem       = len_q[LB-1:0];

    always_comb begin
        for (int i = 0; i < B; i++) begin
            keep_last[i] = (rem == '0) || (i < int'(rem));
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        user_d      = user_q;
        err_d       = err_q;
        beats_rem_d = beats_rem_q;
        burst_d     = burst_q;
        beat_cnt_d  = beat_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (desc_valid) begin
                    addr_d  = desc[AW-1:0];
                    len_d   = desc[LW+AW-1:AW];
                    user_d  = desc_user;
                    err_d   = '0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (len_q == '0) begin
                    err_d[ST_ZERO_LEN] = 1'b1;
                end
                if (addr_q[LB-1:0] != '0) begin
                    err_d[ST_MISALIGN] = 1'b1;
                end
                if ((len_q == '0) || (addr_q[LB-1:0] != '0)) begin
                    state_d = S_STAT;
                end else begin
                    // ceil(len/B) without risking overflow of len+B-1
                    beats_rem_d = (len_q >> LB) + LW'(|len_q[LB-1:0]);
                    state_d     = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bus.m_axi_arready) begin
                    burst_d    = burst_nxt;
                    beat_cnt_d = '0;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (beat) begin
                    beats_rem_d = beats_rem_q - LW'(1);
                    beat_cnt_d  = beat_cnt_q + 9'd1;
                    if (bus.m_axi_rresp == SLVERR) err_d[ST_SLVERR] = 1'b1;
                    if (bus.m_axi_rresp == DECERR) err_d[ST_DECERR] = 1'b1;
                    // burst end follows our own beat count, not rlast
                    if (beat_cnt_q == burst_q - 9'd1) begin
                        if (last_beat) begin
                            state_d = S_STAT;
                        end else begin
                            addr_d  = addr_q + (AW'(burst_q) << LB);
                            state_d = S_ADDR;
                        end
                    end
                end
            end
            S_STAT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            user_q      <= '0;
            err_q       <= '0;
            beats_rem_q <= '0;
            burst_q     <= '0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            user_q      <= user_d;
            err_q       <= err_d;
            beats_rem_q <= beats_rem_d;
            burst_q     <= burst_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign desc_ready         = rstn && (state_q == S_IDLE);
    assign status_valid       = (state_q == S_STAT);
    assign status_error       = err_q;

    assign bus.m_axi_arvalid  = (state_q == S_ADDR);
    assign bus.m_axi_araddr   = addr_q;
    assign bus.m_axi_arlen    = 8'(burst_nxt - 9'd1);
    assign bus.m_axi_arsize   = 3'(LB);
    assign bus.m_axi_arburst  = INCR;
    assign bus.m_axi_rready   = (state_q == S_DATA) && bus.m_axis_tready;

    assign bus.m_axis_tvalid  = (state_q == S_DATA) && bus.m_axi_rvalid;
    assign bus.m_axis_tdata   = bus.m_axi_rdata;
    assign bus.m_axis_tuser   = user_q;
    assign bus.m_axis_tlast   = (state_q == S_DATA) && last_beat;
    assign bus.m_axis_tkeep   = last_beat ? keep_last : '1;

`ifdef MM2S_PERF_CNT_EN
    logic [31:0] busy_q, busy_d;
    logic [31:0] stall_q, stall_d;

    always_comb begin
        busy_d  = busy_q;
        stall_d = stall_q;
        if ((state_q == S_IDLE) && desc_valid) begin
            busy_d = '0;
        end else if ((state_q != S_IDLE) && (busy_q != '1)) begin
            busy_d = busy_q + 32'd1;
        end
        if (bus.m_axis_tvalid && !bus.m_axis_tready && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_q  <= '0;
            stall_q <= '0;
        end else begin
            busy_q  <= busy_d;
            stall_q <= stall_d;
        end
    end

    assign perf_busy_cycles  = busy_q;
    assign perf_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_axis_mm2s_mover.sv
// Directed bench for axis_mm2s_mover: vector table plus reset sequences.
// A small AXI read slave returns data derived from the beat address.
module tb_axis_mm2s_mover;
    import mm2s_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [63:0] desc = '0;
    logic [64:0] desc_user = '0;
    logic        desc_valid = 1'b0;
    logic        desc_ready;
    logic [3:0]  status_error;
    logic        status_valid;
`ifdef MM2S_PERF_CNT_EN
    logic [31:0] perf_busy_cycles;
    logic [31:0] perf_stall_cycles;
`endif

    always #5 clk = ~clk;

    axis_mm2s_mover_if #(.AW(32), .DW(32), .UW(65)) bus ();

    axis_mm2s_mover dut (
        .clk               (clk),
        .rstn              (rstn),
        .desc              (desc),
        .desc_user         (desc_user),
        .desc_valid        (desc_valid),
        .desc_ready        (desc_ready),
        .status_error      (status_error),
        .status_valid      (status_valid),
`ifdef MM2S_PERF_CNT_EN
        .perf_busy_cycles  (perf_busy_cycles),
        .perf_stall_cycles (perf_stall_cycles),
`endif
        .bus               (bus)
    );

    typedef struct {
        logic [31:0] len;
        logic [31:0] addr;
        logic [64:0] user;
        int          err_beat;
        logic [1:0]  err_resp;
        bit          tog;
        logic [3:0]  exp_err;
        int          exp_nar;
        int          exp_beats;
        logic [3:0]  exp_lkeep;
        logic [31:0] exp_ar0_addr;
        logic [7:0]  exp_ar0_len;
    } vec_t;

    int n_tests = 0;
    int n_fail = 0;

    int          cyc = 0;
    bit          tog_mode = 0;
    bit          desc_pend = 0;
    int          acc_cyc, first_ar_cyc, stat_cyc;
    int          n_ar, n_stat, ar_unstable, rr_bad;
    logic [31:0] ar0_addr;
    logic [7:0]  ar0_len;
    bit          ar_hold;
    logic [31:0] ar_hold_addr;
    logic [7:0]  ar_hold_len;
    int          ar_wait;
    bit          rd_busy;
    logic [31:0] rd_addr;
    int          rd_left;
    int          gbeat;
    int          err_beat;
    logic [1:0]  err_resp;
    logic [3:0]  stat_err;
    logic [31:0] q_data[$];
    logic [3:0]  q_keep[$];
    logic        q_last[$];
    logic [64:0] q_user[$];

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {8'hC3, a[23:0]};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        acc_cyc = -1; first_ar_cyc = -1; stat_cyc = -1;
        n_ar = 0; n_stat = 0; ar_unstable = 0; rr_bad = 0;
        ar_hold = 0; ar_wait = 1; rd_busy = 0; rd_left = 0;
        rd_addr = '0; gbeat = 0; err_beat = -1; err_resp = OKAY;
        q_data.delete(); q_keep.delete(); q_last.delete(); q_user.delete();
    endtask

    // One clock: drive at negedge, then observe what the next posedge takes.
    task automatic step();
        @(negedge clk);
        cyc++;
        bus.m_axis_tready = tog_mode ? ((cyc % 2) == 0) : 1'b1;
        desc_valid        = desc_pend;
        bus.m_axi_arready = !rd_busy && (ar_wait == 0);
        bus.m_axi_rvalid  = rd_busy;
        bus.m_axi_rdata   = rd_busy ? pat(rd_addr) : 32'h0;
        bus.m_axi_rresp   = (rd_busy && gbeat == err_beat) ? err_resp : OKAY;
        bus.m_axi_rlast   = rd_busy && (rd_left == 1);
        #1;
        if (status_valid) begin
            n_stat++;
            stat_cyc = cyc;
            stat_err = status_error;
        end
        if (!rstn) return;
        if (desc_valid && desc_ready) begin
            desc_pend = 0;
            acc_cyc = cyc;
        end
        if (bus.m_axi_arvalid) begin
            if (first_ar_cyc < 0) first_ar_cyc = cyc;
            if (ar_hold && (bus.m_axi_araddr !== ar_hold_addr ||
                            bus.m_axi_arlen !== ar_hold_len))
                ar_unstable++;
            ar_hold = 1;
            ar_hold_addr = bus.m_axi_araddr;
            ar_hold_len = bus.m_axi_arlen;
            if (bus.m_axi_arready) begin
                n_ar++;
                if (n_ar == 1) begin
                    ar0_addr = bus.m_axi_araddr;
                    ar0_len = bus.m_axi_arlen;
                end
                rd_busy = 1;
                rd_addr = bus.m_axi_araddr;
                rd_left = int'(bus.m_axi_arlen) + 1;
                ar_hold = 0;
            end else if (ar_wait > 0) begin
                ar_wait--;
            end
        end
        if (bus.m_axi_rvalid && (bus.m_axi_rready !== bus.m_axis_tready))
            rr_bad++;
        if (bus.m_axi_rvalid && bus.m_axi_rready) begin
            rd_addr += 32'd4;
            rd_left--;
            gbeat++;
            if (rd_left == 0) begin
                rd_busy = 0;
                ar_wait = 1;
            end
        end
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            q_data.push_back(bus.m_axis_tdata);
            q_keep.push_back(bus.m_axis_tkeep);
            q_last.push_back(bus.m_axis_tlast);
            q_user.push_back(bus.m_axis_tuser);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string p;
        int    nb;
        p = $sformatf("v%0d", idx);
        model_clear();
        desc = {v.len, v.addr};
        desc_user = v.user;
        err_beat = v.err_beat;
        err_resp = v.err_resp;
        tog_mode = v.tog;
        desc_pend = 1;
        for (int k = 0; k < 1500 && n_stat == 0; k++) step();
        step();
        step();
        tog_mode = 0;
        chk({p, " stat_cnt"}, 128'(n_stat), 128'(1));
        chk({p, " stat_err"}, 128'(stat_err), 128'(v.exp_err));
        chk({p, " n_ar"}, 128'(n_ar), 128'(v.exp_nar));
        if (v.exp_nar > 0) begin
            chk({p, " ar0_addr"}, 128'(ar0_addr), 128'(v.exp_ar0_addr));
            chk({p, " ar0_len"}, 128'(ar0_len), 128'(v.exp_ar0_len));
            chk({p, " ar_lat"}, 128'(first_ar_cyc - acc_cyc), 128'(2));
            chk({p, " ar_stable"}, 128'(ar_unstable), 128'(0));
            chk({p, " rready_track"}, 128'(rr_bad), 128'(0));
        end else begin
            chk({p, " stat_lat"}, 128'(stat_cyc - acc_cyc), 128'(2));
        end
        nb = q_data.size();
        chk({p, " beats"}, 128'(nb), 128'(v.exp_beats));
        for (int i = 0; i < nb && i < v.exp_beats; i++) begin
            chk($sformatf("%s b%0d data", p, i), 128'(q_data[i]),
                128'(pat(v.addr + 32'(4 * i))));
            chk($sformatf("%s b%0d keep", p, i), 128'(q_keep[i]),
                128'((i == v.exp_beats - 1) ? v.exp_lkeep : 4'hF));
            chk($sformatf("%s b%0d last", p, i), 128'(q_last[i]),
                128'(i == v.exp_beats - 1));
            chk($sformatf("%s b%0d user", p, i), 128'(q_user[i]),
                128'(v.user));
        end
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{32'd64,   32'h1000, 65'h5, -1, OKAY, 0,
                    4'b0000, 1, 16, 4'hF, 32'h1000, 8'd15};
        vecs[1] = '{32'd70,   32'h0FF8, {1'b1, 64'hA5A5_0123_4567_89AB},
                    -1, OKAY, 0, 4'b0000, 2, 18, 4'b0011, 32'h0FF8, 8'd1};
        vecs[2] = '{32'd0,    32'h1000, 65'h1, -1, OKAY, 0,
                    4'b0100, 0, 0, 4'hF, 32'h0, 8'd0};
        vecs[3] = '{32'd8,    32'h1002, 65'h2, -1, OKAY, 0,
                    4'b1000, 0, 0, 4'hF, 32'h0, 8'd0};
        vecs[4] = '{32'd32,   32'h2000, 65'h7, 2, SLVERR, 0,
                    4'b0001, 1, 8, 4'hF, 32'h2000, 8'd7};
        vecs[5] = '{32'd32,   32'h3000, 65'h9, -1, OKAY, 1,
                    4'b0000, 1, 8, 4'hF, 32'h3000, 8'd7};
        vecs[6] = '{32'd0,    32'h1003, 65'h3, -1, OKAY, 0,
                    4'b1100, 0, 0, 4'hF, 32'h0, 8'd0};
        vecs[7] = '{32'd4,    32'h4000, 65'h4, 0, DECERR, 0,
                    4'b0010, 1, 1, 4'hF, 32'h4000, 8'd0};
        vecs[8] = '{32'd99,   32'h0FC0, 65'h6, -1, OKAY, 0,
                    4'b0000, 2, 25, 4'b0111, 32'h0FC0, 8'd15};

        bus.m_axis_tready = 1'b1;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rdata   = '0;
        bus.m_axi_rresp   = OKAY;
        bus.m_axi_rlast   = 1'b0;
        model_clear();

        rstn = 0;
        step();
        step();
        chk("rst desc_ready", 128'(desc_ready), 128'(0));
        chk("rst arvalid", 128'(bus.m_axi_arvalid), 128'(0));
        chk("rst tvalid", 128'(bus.m_axis_tvalid), 128'(0));
        chk("rst status_valid", 128'(status_valid), 128'(0));
        chk("rst status_error", 128'(status_error), 128'(0));
        rstn = 1;
        step();
        chk("rel desc_ready", 128'(desc_ready), 128'(1));

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Reset in the middle of a data phase
        model_clear();
        desc = {32'd64, 32'h5000};
        desc_user = 65'h11;
        desc_pend = 1;
        for (int k = 0; k < 100 && q_data.size() < 5; k++) step();
        chk("mid beats_before_rst", 128'(q_data.size() >= 5), 128'(1));
        rstn = 0;
        step();
        chk("mid rst tvalid", 128'(bus.m_axis_tvalid), 128'(0));
        chk("mid rst arvalid", 128'(bus.m_axi_arvalid), 128'(0));
        chk("mid rst rready", 128'(bus.m_axi_rready), 128'(0));
        chk("mid rst status_valid", 128'(status_valid), 128'(0));
        chk("mid rst desc_ready", 128'(desc_ready), 128'(0));
        rd_busy = 0;
        rd_left = 0;
        ar_wait = 1;
        step();
        rstn = 1;
        step();
        chk("mid rel desc_ready", 128'(desc_ready), 128'(1));
        for (int k = 0; k < 5; k++) step();
        chk("mid no_status", 128'(n_stat), 128'(0));
        chk("mid no_arvalid", 128'(bus.m_axi_arvalid), 128'(0));

        run_vec(vecs[0], 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
